simple_merger: RTL

Four-input, one-output round-robin merger with a single registered output stage. It forms the return path of the 4-way address router: it collects words from four source channels and forwards them on one stream, tagged with the 2-bit source address. This tag uses the same encoding the router decodes. Each input and the output use a valid/ready handshake, and arbitration among simultaneous requesters is round-robin and starvation-free.

---
 rtl/simple_merger_if.sv | 25 ++
 rtl/simple_merger.sv | 85 ++++++++
 2 files changed

// File: rtl/simple_merger_if.sv
// Handshake bundle between four source channels, the merger and its downstream sink.
interface simple_merger_if #(
  parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] din1;
    logic [DATA_WIDTH-1:0] din2;
    logic [DATA_WIDTH-1:0] din3;
    logic [3:0]            din_en;
    logic [3:0]            din_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic [1:0]            dout_addr;
    logic                  dout_valid;
    logic                  dout_ready;

    modport slave (
        input  din0, din1, din2, din3, din_en, dout_ready,
        output din_ready, dout, dout_addr, dout_valid
    );

    modport master (
        output din0, din1, din2, din3, din_en, dout_ready,
        input  din_ready, dout, dout_addr, dout_valid
    );
endinterface

// File: rtl/simple_merger.sv
// Four-way round-robin merger with one registered output stage; each word is
// tagged with the index of the source it came from.
module simple_merger_lane #(
    parameter int IDX = 0
) (
    input  logic       load_en,
    input  logic       hit,
    input  logic [1:0] win,
    output logic       ready
);
    assign ready = load_en && hit && (win == 2'(IDX));
endmodule

module simple_merger #(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    simple_merger_if.slave   bus
);
    localparam int NUM_LANES = 4;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            addr;
    } word_t;

    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] din_vec;
    logic [NUM_LANES-1:0]                 ready_vec;
    word_t                                out_q;
    logic                                 out_vld;
    logic [1:0]                           ptr;
    logic                                 load_en;
    logic                                 lane_en;
    logic                                 hit;
    logic [1:0]                           win;

    assign din_vec = {bus.din3, bus.din2, bus.din1, bus.din0};
    assign load_en = !out_vld || bus.dout_ready;
    // No grants while reset is held, even though the register reads empty.
    assign lane_en = load_en && !reset;

    // Rotating search from ptr; the 2-bit add wraps naturally mod 4.
    always_comb begin
        hit = 1'b0;
        win = ptr;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!hit && bus.din_en[ptr + 2'(k)]) begin
                hit = 1'b1;
                win = ptr + 2'(k);
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        simple_merger_lane #(.IDX(i)) u_lane (
            .load_en (lane_en),
            .hit     (hit),
            .win     (win),
            .ready   (ready_vec[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            out_vld <= 1'b0;
            ptr     <= 2'd0;
        end else if (load_en) begin
            if (hit) begin
                out_q.data <= din_vec[win];
                out_q.addr <= win;
                out_vld    <= 1'b1;
                ptr        <= win + 2'd1;
            end else begin
                out_vld    <= 1'b0;
            end
        end
    end

    assign bus.din_ready  = ready_vec;
    assign bus.dout       = out_q.data;
    assign bus.dout_addr  = out_q.addr;
    assign bus.dout_valid = out_vld;
endmodule
